// File: rtl/csr_access_sequencer.sv
// Zicsr access sequencer for the misa/mcycle/minstret CSR store: IDLE -> EXEC -> RESP.
// Optional mcountinhibit (0x320) is built when CSR_COUNTER_INHIBIT_EN is defined.
module csr_access_sequencer #(
  parameter logic [31:0] MISA_VALUE   = 32'h4000_0100,
  parameter logic [63:0] MCYCLE_RESET = 64'h0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_insn,
  input  logic [31:0] req_rs1_rdata,
  input  logic [1:0]  req_mode,
  input  logic        instret_inc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_trap,
  output logic [4:0]  rsp_rd_addr,
  output logic [31:0] rsp_rd_wdata,
  output logic [63:0] rsp_csr_rmask,
  output logic [63:0] rsp_csr_wmask,
  output logic [63:0] rsp_csr_rdata,
  output logic [63:0] rsp_csr_wdata
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e      state_q;
  logic [31:7] insn_q;
  logic [31:0] rs1_q;
  logic [1:0]  mode_q;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;

  logic [11:0] addr;
  logic        hi, sel_misa, sel_cyc, sel_ir, sel_inh;
  logic        wr_en, rd_en, trap, commit;
  logic [63:0] pair, new_pair, half_mask, wmask_val;
  logic [31:0] old_half, new_half, arg;
  logic        cy_run, ir_run;

`ifdef CSR_COUNTER_INHIBIT_EN
  logic [1:0] inhibit_q;  // [0] = CY, [1] = IR
  assign cy_run = !inhibit_q[0];
  assign ir_run = instret_inc && !inhibit_q[1];
`else
  assign cy_run = 1'b1;
  assign ir_run = instret_inc;
`endif

  always_comb begin
    addr     = insn_q[31:20];
    hi       = addr[7];
    sel_misa = (addr == 12'h301);
    sel_cyc  = (addr == 12'hB00) || (addr == 12'hB80) || (addr == 12'hC00) || (addr == 12'hC80);
    sel_ir   = (addr == 12'hB02) || (addr == 12'hB82) || (addr == 12'hC02) || (addr == 12'hC82);
    sel_inh  = 1'b0;
    pair     = 64'h0;
    if (sel_misa) pair = {32'h0, MISA_VALUE};
    if (sel_cyc)  pair = mcycle_q;
    if (sel_ir)   pair = minstret_q;
`ifdef CSR_COUNTER_INHIBIT_EN
    sel_inh = (addr == 12'h320);
    if (sel_inh) pair = {32'h0, 29'h0, inhibit_q[1], 1'b0, inhibit_q[0]};
`endif
    wr_en = !insn_q[13] || (insn_q[19:15] != 5'd0);
    rd_en = (insn_q[11:7] != 5'd0);
    trap  = !(sel_misa || sel_cyc || sel_ir || sel_inh) || (mode_q < addr[9:8]) ||
            ((addr[11:10] == 2'b11) && wr_en);

    old_half = hi ? pair[63:32] : pair[31:0];
    arg      = insn_q[14] ? {27'h0, insn_q[19:15]} : rs1_q;
    unique case (insn_q[13:12])
      2'b01:   new_half = arg;
      2'b10:   new_half = old_half | arg;
      2'b11:   new_half = old_half & ~arg;
      default: new_half = old_half;
    endcase
    // Only CY and IR are implemented in mcountinhibit.
    if (sel_inh) new_half = new_half & 32'h5;

    new_pair = hi ? {new_half, pair[31:0]} : {pair[63:32], new_half};
    if (sel_misa) new_pair = pair;  // WARL: writes ignored

    half_mask = hi ? {32'hFFFF_FFFF, 32'h0} : {32'h0, 32'hFFFF_FFFF};
    wmask_val = sel_inh ? (half_mask & 64'h5) : half_mask;
    commit    = (state_q == StExec) && !trap && wr_en;
  end

  // A software write wins over the increment of the counter it targets.
  always_comb begin
    mcycle_d   = mcycle_q + {63'h0, cy_run};
    minstret_d = minstret_q + {63'h0, ir_run};
    if (commit && sel_cyc) mcycle_d = new_pair;
    if (commit && sel_ir)  minstret_d = new_pair;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mcycle_q   <= MCYCLE_RESET;
      minstret_q <= 64'h0;
`ifdef CSR_COUNTER_INHIBIT_EN
      inhibit_q  <= 2'b00;
`endif
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
`ifdef CSR_COUNTER_INHIBIT_EN
      if (commit && sel_inh) inhibit_q <= {new_half[2], new_half[0]};
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      req_ready     <= 1'b1;
      insn_q        <= '0;
      rs1_q         <= 32'h0;
      mode_q        <= 2'b00;
      rsp_valid     <= 1'b0;
      rsp_trap      <= 1'b0;
      rsp_rd_addr   <= 5'd0;
      rsp_rd_wdata  <= 32'h0;
      rsp_csr_rmask <= 64'h0;
      rsp_csr_wmask <= 64'h0;
      rsp_csr_rdata <= 64'h0;
      rsp_csr_wdata <= 64'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            insn_q    <= req_insn[31:7];
            rs1_q     <= req_rs1_rdata;
            mode_q    <= req_mode;
            req_ready <= 1'b0;
            state_q   <= StExec;
          end
        end
        StExec: begin
          rsp_valid     <= 1'b1;
          rsp_trap      <= trap;
          rsp_rd_addr   <= trap ? 5'd0 : insn_q[11:7];
          rsp_rd_wdata  <= (!trap && rd_en) ? old_half : 32'h0;
          rsp_csr_rmask <= (!trap && rd_en) ? half_mask : 64'h0;
          rsp_csr_wmask <= (!trap && wr_en && !sel_misa) ? wmask_val : 64'h0;
          rsp_csr_rdata <= trap ? 64'h0 : pair;
          rsp_csr_wdata <= trap ? 64'h0 : new_pair;
          state_q       <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
